// File: rtl/logic_issue_ctrl_pkg.sv
// Shared types and constants for the logic-unit issue controller:
// funct3 encodings, logic-unit operation codes and the in-flight tag layout.
package logic_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_XOR = 3'd0,
        OP_OR  = 3'd1,
        OP_AND = 3'd2
    } lu_op_e;

    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam int unsigned RD_W     = 5;
    // Writeback entry carries {err, rd} above the XLEN-wide result
    localparam int unsigned WB_TAG_W = RD_W + 1;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            err;
    } tag_t;

    typedef struct packed {
        lu_op_e op;
        logic   err;
    } decode_t;

    // Unsupported funct3 still drives AND so the unit sees a defined opcode
    function automatic decode_t decode_funct3(input logic [2:0] f3);
        decode_t d;
        d.op  = OP_AND;
        d.err = 1'b0;
        case (f3)
            F3_XOR:  d.op = OP_XOR;
            F3_OR:   d.op = OP_OR;
            F3_AND:  d.op = OP_AND;
            default: d.err = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/logic_issue_ctrl_if.sv
// Request, logic-unit and writeback signal bundle for logic_issue_ctrl.
// master = surrounding pipeline / logic unit, slave = the controller.
interface logic_issue_ctrl_if #(
    parameter int unsigned XLEN = 32
) ();
    import logic_issue_ctrl_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_op_a;
    logic [XLEN-1:0] req_op_b;
    logic [2:0]      req_funct3;
    logic [RD_W-1:0] req_rd;

    logic [XLEN-1:0] lu_op_a;
    logic [XLEN-1:0] lu_op_b;
    logic [2:0]      lu_instr_type;
    logic [XLEN-1:0] lu_result;

    logic            wb_valid;
    logic            wb_ready;
    logic [XLEN-1:0] wb_data;
    logic [RD_W-1:0] wb_rd;
    logic            wb_err;
    logic            busy;

    modport master (
        output req_valid, req_op_a, req_op_b, req_funct3, req_rd,
        output lu_result, wb_ready,
        input  req_ready, lu_op_a, lu_op_b, lu_instr_type,
        input  wb_valid, wb_data, wb_rd, wb_err, busy
    );

    modport slave (
        input  req_valid, req_op_a, req_op_b, req_funct3, req_rd,
        input  lu_result, wb_ready,
        output req_ready, lu_op_a, lu_op_b, lu_instr_type,
        output wb_valid, wb_data, wb_rd, wb_err, busy
    );

endinterface

// File: rtl/lu_result_fifo.sv
// Synchronous show-ahead FIFO holding completed logic-unit results.
// head is valid whenever empty is low; pop on an empty FIFO is ignored.
module lu_result_fifo #(
    parameter int unsigned WIDTH = 38,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Upstream credit accounting must make overflow unreachable
    assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/logic_issue_ctrl.sv
// Requester side of the registered-output logic unit: decodes XOR/OR/AND ops,
// drives the unit, tracks in-flight tags and returns results in order.
module logic_issue_ctrl
    import logic_issue_ctrl_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned DEPTH   = 4
) (
    input logic               i_clk,
    input logic               i_rst,
    logic_issue_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned WB_W  = XLEN + WB_TAG_W;

    decode_t          dec;
    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;
    logic [XLEN-1:0]  lu_op_a_q;
    logic [XLEN-1:0]  lu_op_b_q;
    logic [2:0]       lu_type_q;
    tag_t             pipe [0:LATENCY];
    logic [XLEN-1:0]  push_res;
    logic [WB_W-1:0]  push_data;
    logic [WB_W-1:0]  head;

    assign dec    = decode_funct3(bus.req_funct3);
    assign accept = bus.req_valid && bus.req_ready;

    // Credit counts both buffered and in-flight ops; a same-cycle pop is not reused
    assign credit_used   = {1'b0, fifo_count} + {1'b0, inflight};
    assign bus.req_ready = !i_rst && (credit_used < (CNT_W + 1)'(DEPTH));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lu_op_a_q <= '0;
            lu_op_b_q <= '0;
            lu_type_q <= '0;
        end else if (accept) begin
            lu_op_a_q <= bus.req_op_a;
            lu_op_b_q <= bus.req_op_b;
            lu_type_q <= dec.op;
        end
    end

    assign bus.lu_op_a       = lu_op_a_q;
    assign bus.lu_op_b       = lu_op_b_q;
    assign bus.lu_instr_type = lu_type_q;

    // Stage k holds the tag of the op accepted k edges ago
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i <= LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= accept ? tag_t'{valid: 1'b1, rd: bus.req_rd, err: dec.err} : '0;
            for (int unsigned i = 1; i <= LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign push = pipe[LATENCY].valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inflight <= '0;
        end else if (accept && !push) begin
            inflight <= inflight + CNT_W'(1);
        end else if (!accept && push) begin
            inflight <= inflight - CNT_W'(1);
        end
    end

    assign push_res  = pipe[LATENCY].err ? '0 : bus.lu_result;
    assign push_data = {pipe[LATENCY].err, pipe[LATENCY].rd, push_res};

    lu_result_fifo #(
        .WIDTH (WB_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.wb_valid = !i_rst && !fifo_empty;
    assign pop          = bus.wb_valid && bus.wb_ready;
    assign bus.wb_data  = head[XLEN-1:0];
    assign bus.wb_rd    = head[XLEN +: RD_W];
    assign bus.wb_err   = head[WB_W-1];
    assign bus.busy     = !i_rst && ((inflight != '0) || !fifo_empty);

endmodule

// File: tb/tb_logic_issue_ctrl.sv
// Scoreboard bench for logic_issue_ctrl with a one-register logic-unit model.
module tb_logic_issue_ctrl;
    import logic_issue_ctrl_pkg::*;

    localparam int unsigned XLEN = 32;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   pop_cyc[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    logic_issue_ctrl_if #(.XLEN(XLEN)) bus ();

    logic_issue_ctrl #(
        .XLEN    (XLEN),
        .LATENCY (1),
        .DEPTH   (4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // External logic unit: registers its result once
    always @(posedge clk) begin
        case (bus.lu_instr_type)
            OP_XOR:  bus.lu_result <= bus.lu_op_a ^ bus.lu_op_b;
            OP_OR:   bus.lu_result <= bus.lu_op_a | bus.lu_op_b;
            OP_AND:  bus.lu_result <= bus.lu_op_a & bus.lu_op_b;
            default: bus.lu_result <= '0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes at the next posedge
    always @(negedge clk) begin
        if (bus.wb_valid && bus.wb_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected actual=rd%0d/%0h required=none", bus.wb_rd, bus.wb_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_data", bus.wb_data, mon_e.data);
                chk("wb_rd", bus.wb_rd, mon_e.rd);
                chk("wb_err", bus.wb_err, mon_e.err);
            end
        end
    end

    task automatic try_send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                            input logic [4:0] rd, input logic [31:0] ed, input logic ee,
                            output bit acc);
        logic rdy;
        bus.req_valid  = 1'b1;
        bus.req_op_a   = a;
        bus.req_op_b   = b;
        bus.req_funct3 = f3;
        bus.req_rd     = rd;
        @(negedge clk);
        rdy = bus.req_ready;
        @(posedge clk);
        #1;
        acc = rdy;
        if (rdy) exp_q.push_back('{ed, rd, ee});
        bus.req_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] ed, input logic ee);
        bit acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            try_send(a, b, f3, rd, ed, ee, acc);
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=not_accepted required=accepted rd=%0d", rd);
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
        end
    endtask

    vec_t t4 [6];
    int   idx;
    int   n;
    bit   acc;

    initial begin
        bus.req_valid  = 1'b1;
        bus.req_op_a   = 32'hDEAD_BEEF;
        bus.req_op_b   = 32'h1234_5678;
        bus.req_funct3 = F3_OR;
        bus.req_rd     = 5'd1;
        bus.wb_ready   = 1'b1;

        // 1. reset with a pending request
        repeat (3) begin
            @(negedge clk);
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_wb_valid", bus.wb_valid, 0);
            chk("rst_busy", bus.busy, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus.req_ready, 1);
        chk("post_rst_lu_a", bus.lu_op_a, 0);
        chk("post_rst_lu_b", bus.lu_op_b, 0);
        chk("post_rst_lu_type", bus.lu_instr_type, 0);
        @(posedge clk);
        #1;

        // 2. single XOR with latency check
        send(32'hF0F0_F0F0, 32'h0FF0_0FF0, F3_XOR, 5'd5, 32'hFF00_FF00, 1'b0);
        chk("t2_lu_type", bus.lu_instr_type, OP_XOR);
        @(negedge clk);
        chk("t2_valid_e0", bus.wb_valid, 0);
        @(negedge clk);
        chk("t2_valid_e1", bus.wb_valid, 0);
        @(negedge clk);
        chk("t2_valid_e2", bus.wb_valid, 1);
        drain();

        // 3. back-to-back, results on consecutive cycles
        idx = pop_cyc.size();
        send(32'h0000_00FF, 32'h0000_0F00, F3_OR,  5'd1, 32'h0000_0FFF, 1'b0);
        send(32'h0000_FFFF, 32'h0000_0F0F, F3_AND, 5'd2, 32'h0000_0F0F, 1'b0);
        send(32'h0000_AAAA, 32'h0000_5555, F3_XOR, 5'd3, 32'h0000_FFFF, 1'b0);
        drain();
        chk("t3_pops", pop_cyc.size() - idx, 3);
        if (pop_cyc.size() >= idx + 3) begin
            chk("t3_consec_a", pop_cyc[idx+1] - pop_cyc[idx], 1);
            chk("t3_consec_b", pop_cyc[idx+2] - pop_cyc[idx+1], 1);
        end

        // 4. back-pressure: only DEPTH credits
        t4[0] = '{32'h0000_1111, 32'h0000_0101, F3_XOR, 5'd10, 32'h0000_1010};
        t4[1] = '{32'h0000_0010, 32'h0000_0001, F3_OR,  5'd11, 32'h0000_0011};
        t4[2] = '{32'h0000_00FF, 32'h0000_003C, F3_AND, 5'd12, 32'h0000_003C};
        t4[3] = '{32'hFFFF_FFFF, 32'h0000_0001, F3_XOR, 5'd13, 32'hFFFF_FFFE};
        t4[4] = '{32'h0000_0001, 32'h0000_0001, F3_AND, 5'd14, 32'h0000_0001};
        t4[5] = '{32'h0000_0002, 32'h0000_0004, F3_OR,  5'd15, 32'h0000_0006};
        bus.wb_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            try_send(t4[i].a, t4[i].b, t4[i].f3, t4[i].rd, t4[i].data, 1'b0, acc);
            if (acc) n++;
        end
        chk("t4_accepted", n, 4);
        @(negedge clk);
        chk("t4_ready_low", bus.req_ready, 0);
        chk("t4_wb_held", bus.wb_valid, 1);
        chk("t4_head_rd", bus.wb_rd, 10);
        @(posedge clk);
        #1;
        bus.wb_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("t4_ready_back", bus.req_ready, 1);
        @(posedge clk);
        #1;

        // 5. unsupported funct3
        send(32'h1234_5678, 32'hFFFF_FFFF, 3'b000, 5'd7, 32'h0, 1'b1);
        chk("t5_lu_type", bus.lu_instr_type, OP_AND);
        drain();

        // 6. reset discards in-flight work
        send(32'h0000_000F, 32'h0000_00F0, F3_OR,  5'd20, 32'h0000_00FF, 1'b0);
        send(32'h0000_000F, 32'h0000_00F0, F3_AND, 5'd21, 32'h0000_0000, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("t6_rst_wb_valid", bus.wb_valid, 0);
            chk("t6_rst_busy", bus.busy, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.wb_valid) n++;
        end
        chk("t6_no_wb", n, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_ready", bus.req_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
